// File: rtl/intra_mb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : intra_mb_scheduler
// Description : Issues block addresses, in raster order, to NUM_ENG intra
//               prediction engines for one plane. Idle engines are served
//               round-robin with at most one outstanding block each. Frame
//               completion is flagged once every block is issued and every
//               engine has returned its feedback.
// Revision    : 1.0 - initial release
// ============================================================================
module intra_mb_scheduler #(
   parameter int NUM_ENG = 2,
   parameter int BLK     = 4,
   parameter int FRAME_W = 1280,
   parameter int FRAME_H = 720
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [NUM_ENG-1:0] eng_req,
   input  logic [NUM_ENG-1:0] eng_fb,
   output logic [NUM_ENG-1:0] eng_grant,
   output logic [31:0]        eng_mbaddr,
   output logic               busy,
   output logic               done,
   output logic [31:0]        blk_issued,
   output logic               err
);

   localparam int          PTR_W      = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
   localparam logic [15:0] c_last_col = 16'(FRAME_W - BLK);
   localparam logic [15:0] c_last_row = 16'(FRAME_H - BLK);
   localparam logic [15:0] c_step     = 16'(BLK);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DISPATCH = 2'd1,
      S_DRAIN    = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t             r_state,   w_state_nxt;
   logic [15:0]        r_row,     w_row_nxt;
   logic [15:0]        r_col,     w_col_nxt;
   logic [NUM_ENG-1:0] r_out,     w_out_nxt;
   logic [PTR_W-1:0]   r_rr,      w_rr_nxt;
   logic [NUM_ENG-1:0] r_grant,   w_grant_nxt;
   logic [31:0]        r_mbaddr,  w_mbaddr_nxt;
   logic [31:0]        r_issued,  w_issued_nxt;
   logic               r_err,     w_err_nxt;

   logic [NUM_ENG-1:0] w_elig;
   logic               w_any;
   logic               w_hi_any;
   logic [PTR_W-1:0]   w_first;
   logic [PTR_W-1:0]   w_hi;
   logic [PTR_W-1:0]   w_win;
   logic [NUM_ENG-1:0] w_win_onehot;
   logic [PTR_W-1:0]   w_rr_after;

   // Round-robin pick: lowest eligible index at/after rr_ptr, else lowest overall (wrap).
   always_comb begin
      w_elig   = eng_req & ~r_out;
      w_any    = 1'b0;
      w_hi_any = 1'b0;
      w_first  = '0;
      w_hi     = '0;
      for (int i = NUM_ENG - 1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_any   = 1'b1;
            w_first = PTR_W'(i);
            if (i >= int'(r_rr)) begin
               w_hi_any = 1'b1;
               w_hi     = PTR_W'(i);
            end
         end
      end
      w_win        = w_hi_any ? w_hi : w_first;
      w_win_onehot = NUM_ENG'(1) << w_win;
      w_rr_after   = (int'(w_win) == NUM_ENG - 1) ? '0 : w_win + 1'b1;
   end

   // Next-state, cursor, outstanding-tracking and grant decision.
   always_comb begin
      w_state_nxt  = r_state;
      w_row_nxt    = r_row;
      w_col_nxt    = r_col;
      w_out_nxt    = r_out & ~eng_fb;
      w_rr_nxt     = r_rr;
      w_grant_nxt  = '0;
      w_mbaddr_nxt = r_mbaddr;
      w_issued_nxt = r_issued;
      // Feedback from an engine that holds no block is a protocol error.
      w_err_nxt    = r_err | (|(eng_fb & ~r_out));

      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt  = S_DISPATCH;
               w_row_nxt    = '0;
               w_col_nxt    = '0;
               w_out_nxt    = '0;
               w_rr_nxt     = '0;
               w_issued_nxt = '0;
            end
         end
         S_DISPATCH: begin
            if (w_any) begin
               w_grant_nxt  = w_win_onehot;
               w_mbaddr_nxt = {r_row, r_col};
               w_out_nxt    = (r_out & ~eng_fb) | w_win_onehot;
               w_rr_nxt     = w_rr_after;
               w_issued_nxt = r_issued + 32'd1;
               // The cursor stays on the final block once it has been granted.
               if (r_row == c_last_row && r_col == c_last_col) begin
                  w_state_nxt = S_DRAIN;
               end else if (r_col == c_last_col) begin
                  w_col_nxt = '0;
                  w_row_nxt = r_row + c_step;
               end else begin
                  w_col_nxt = r_col + c_step;
               end
            end
         end
         S_DRAIN: begin
            if (r_out == '0) begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_row    <= '0;
         r_col    <= '0;
         r_out    <= '0;
         r_rr     <= '0;
         r_grant  <= '0;
         r_mbaddr <= '0;
         r_issued <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_row    <= w_row_nxt;
         r_col    <= w_col_nxt;
         r_out    <= w_out_nxt;
         r_rr     <= w_rr_nxt;
         r_grant  <= w_grant_nxt;
         r_mbaddr <= w_mbaddr_nxt;
         r_issued <= w_issued_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign eng_grant  = r_grant;
   assign eng_mbaddr = r_mbaddr;
   assign busy       = (r_state == S_DISPATCH) || (r_state == S_DRAIN);
   assign done       = (r_state == S_DONE);
   assign blk_issued = r_issued;
   assign err        = r_err;

endmodule
`default_nettype wire
